// File: rtl/task_9_frame_buffer.sv
// Frame input buffer: loads one AXI-stream frame into a FIFO, then replays it
// downstream with valid/ready handshaking, a last-word marker and the frame length.
// Beats beyond DEPTH are dropped and flagged; upstream is never stalled in LOAD.
module task_9_frame_buffer #(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 256,
  localparam int LEN_W  = $clog2(DEPTH) + 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_tdata_valid,
  input  logic [DATA_W-1:0] i_tdata,
  input  logic              i_tdata_last,
  output logic              o_tready,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output logic              o_last,
  input  logic              i_ready,
  output logic              o_busy,
  output logic              o_empty,
  output logic [LEN_W-1:0]  o_frame_len,
  output logic              o_overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [LEN_W-1:0] FULL = LEN_W'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SEND
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [LEN_W-1:0]  count;

  logic accept;
  logic fits;
  logic wr_en;
  logic xfer;
  logic load_out;

  assign accept   = i_tdata_valid & o_tready;
  assign fits     = (count < FULL);
  assign wr_en    = (state == S_LOAD) & accept & fits;
  assign xfer     = o_valid & i_ready;
  // Output register refills when empty or being consumed this cycle.
  assign load_out = (state == S_SEND) & (~o_valid | i_ready) & (count != '0);
  assign o_empty  = (count == '0);

  // FIFO storage write port; no reset needed, occupancy is tracked by count.
  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= i_tdata;
    end
  end

  // Frame FSM with FIFO pointers, count and all registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= S_IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      o_tready    <= 1'b0;
      o_data      <= '0;
      o_valid     <= 1'b0;
      o_last      <= 1'b0;
      o_busy      <= 1'b0;
      o_frame_len <= '0;
      o_overflow  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          state      <= S_LOAD;
          o_tready   <= 1'b1;
          o_busy     <= 1'b1;
          o_overflow <= 1'b0;
        end

        S_LOAD: begin
          if (accept) begin
            if (fits) begin
              wr_ptr <= wr_ptr + PTR_W'(1);
              count  <= count + LEN_W'(1);
            end else begin
              o_overflow <= 1'b1;
            end
            if (i_tdata_last) begin
              state       <= S_SEND;
              o_tready    <= 1'b0;
              o_frame_len <= fits ? (count + LEN_W'(1)) : count;
            end
          end
        end

        S_SEND: begin
          if (load_out) begin
            o_data  <= mem[rd_ptr];
            rd_ptr  <= rd_ptr + PTR_W'(1);
            count   <= count - LEN_W'(1);
            o_valid <= 1'b1;
            o_last  <= (count == LEN_W'(1));
          end else if (xfer) begin
            o_valid <= 1'b0;
            o_last  <= 1'b0;
          end
          // The last word leaves count at zero, so no refill competes with this.
          if (xfer && o_last) begin
            state  <= S_IDLE;
            o_busy <= 1'b0;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_task_9_frame_buffer.sv
// Directed bench for task_9_frame_buffer: a DEPTH=256 instance for the normal
// frame scenarios and a DEPTH=4 instance for truncation, sharing the stimulus.
module tb_task_9_frame_buffer;

  localparam int BIG   = 256;
  localparam int SMALL = 4;
  localparam int BLW   = $clog2(BIG) + 1;
  localparam int SLW   = $clog2(SMALL) + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       tvalid = 1'b0;
  logic       tlast = 1'b0;
  logic [7:0] tdata = '0;
  logic       ready = 1'b0;
  logic       use_small = 1'b0;

  logic           b_tvalid, b_ready, b_tready, b_valid, b_last, b_busy, b_empty, b_ovf;
  logic [7:0]     b_data;
  logic [BLW-1:0] b_len;
  logic           s_tvalid, s_ready, s_tready, s_valid, s_last, s_busy, s_empty, s_ovf;
  logic [7:0]     s_data;
  logic [SLW-1:0] s_len;

  logic           m_tready, m_valid, m_last, m_busy, m_empty, m_ovf;
  logic [7:0]     m_data;
  logic [BLW-1:0] m_len;

  logic [7:0] frame [16];
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  assign b_tvalid = tvalid & ~use_small;
  assign b_ready  = ready & ~use_small;
  assign s_tvalid = tvalid & use_small;
  assign s_ready  = ready & use_small;

  assign m_tready = use_small ? s_tready : b_tready;
  assign m_valid  = use_small ? s_valid  : b_valid;
  assign m_last   = use_small ? s_last   : b_last;
  assign m_busy   = use_small ? s_busy   : b_busy;
  assign m_empty  = use_small ? s_empty  : b_empty;
  assign m_ovf    = use_small ? s_ovf    : b_ovf;
  assign m_data   = use_small ? s_data   : b_data;
  assign m_len    = use_small ? {{(BLW-SLW){1'b0}}, s_len} : b_len;

  task_9_frame_buffer #(.DATA_W(8), .DEPTH(BIG)) u_big (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_tdata_valid(b_tvalid), .i_tdata(tdata), .i_tdata_last(tlast),
    .o_tready(b_tready), .o_data(b_data), .o_valid(b_valid), .o_last(b_last),
    .i_ready(b_ready), .o_busy(b_busy), .o_empty(b_empty),
    .o_frame_len(b_len), .o_overflow(b_ovf)
  );

  task_9_frame_buffer #(.DATA_W(8), .DEPTH(SMALL)) u_small (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_tdata_valid(s_tvalid), .i_tdata(tdata), .i_tdata_last(tlast),
    .o_tready(s_tready), .o_data(s_data), .o_valid(s_valid), .o_last(s_last),
    .i_ready(s_ready), .o_busy(s_busy), .o_empty(s_empty),
    .o_frame_len(s_len), .o_overflow(s_ovf)
  );

  task automatic check_reset_values(input string tag);
    total++;
    if (m_tready !== 1'b0 || m_valid !== 1'b0 || m_last !== 1'b0 || m_busy !== 1'b0 ||
        m_ovf !== 1'b0 || m_data !== 8'h00 || m_len !== '0 || m_empty !== 1'b1) begin
      bad++;
      $display("FAIL %s: tready=%b valid=%b last=%b busy=%b ovf=%b data=%h len=%0d empty=%b want 0,0,0,0,0,00,0,1",
               tag, m_tready, m_valid, m_last, m_busy, m_ovf, m_data, m_len, m_empty);
    end
  endtask

  // Waits for tready, pushes n beats from frame[], then checks the SEND entry state.
  task automatic load_frame(input int n, input int exp_len, input logic exp_ovf);
    int cyc = 0;
    while (m_tready !== 1'b1 && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
    end
    total++;
    if (m_tready !== 1'b1) begin
      bad++;
      $display("FAIL load_wait_ready: tready=%b want 1", m_tready);
    end
    for (int i = 0; i < n; i++) begin
      total++;
      if (m_tready !== 1'b1 || m_busy !== 1'b1) begin
        bad++;
        $display("FAIL load_beat%0d: tready=%b busy=%b want 1,1", i, m_tready, m_busy);
      end
      tvalid = 1'b1;
      tdata  = frame[i];
      tlast  = (i == n - 1);
      @(posedge clk); #1;
    end
    tvalid = 1'b0;
    tlast  = 1'b0;
    tdata  = '0;
    total++;
    if (m_tready !== 1'b0 || m_len !== BLW'(exp_len) || m_ovf !== exp_ovf ||
        m_empty !== 1'b0 || m_valid !== 1'b0 || m_busy !== 1'b1) begin
      bad++;
      $display("FAIL load_end: tready=%b len=%0d ovf=%b empty=%b valid=%b busy=%b want 0,%0d,%b,0,0,1",
               m_tready, m_len, m_ovf, m_empty, m_valid, m_busy, exp_len, exp_ovf);
    end
  endtask

  // Drains n words with a repeating 4-cycle ready pattern, checking order, o_last and holds.
  task automatic drain_frame(input int n, input logic [3:0] pat);
    int         got = 0;
    logic       stalled = 1'b0;
    logic [7:0] held = '0;
    logic       exp_last;
    for (int c = 0; c < 100 && got < n; c++) begin
      ready = pat[c % 4];
      total++;
      if (m_tready !== 1'b0) begin
        bad++;
        $display("FAIL send_tready: tready=%b want 0 at cycle %0d", m_tready, c);
      end
      if (stalled) begin
        total++;
        if (m_valid !== 1'b1 || m_data !== held) begin
          bad++;
          $display("FAIL send_hold: valid=%b data=%h want 1,%h", m_valid, m_data, held);
        end
      end
      if (m_valid === 1'b1) begin
        if (ready) begin
          exp_last = (got == n - 1);
          total++;
          if (m_data !== frame[got] || m_last !== exp_last) begin
            bad++;
            $display("FAIL send_word%0d: data=%h last=%b want %h,%b",
                     got, m_data, m_last, frame[got], exp_last);
          end
          got++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held    = m_data;
        end
      end
      @(posedge clk); #1;
    end
    ready = 1'b0;
    total++;
    if (got != n) begin
      bad++;
      $display("FAIL send_count: got=%0d want %0d", got, n);
    end
    total++;
    if (m_valid !== 1'b0 || m_last !== 1'b0 || m_busy !== 1'b0 || m_empty !== 1'b1) begin
      bad++;
      $display("FAIL send_idle: valid=%b last=%b busy=%b empty=%b want 0,0,0,1",
               m_valid, m_last, m_busy, m_empty);
    end
  endtask

  task automatic test_reset;
    #2 rst_n = 1'b0;
    #1;
    check_reset_values("reset_values");
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    total++;
    if (m_tready !== 1'b0 || m_busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle: tready=%b busy=%b want 0,0", m_tready, m_busy);
    end
    @(posedge clk); #1;
    total++;
    if (m_tready !== 1'b1 || m_busy !== 1'b1 || m_ovf !== 1'b0) begin
      bad++;
      $display("FAIL reset_to_load: tready=%b busy=%b ovf=%b want 1,1,0", m_tready, m_busy, m_ovf);
    end
  endtask

  task automatic test_basic;
    for (int i = 0; i < 5; i++) frame[i] = 8'(i + 1);
    load_frame(5, 5, 1'b0);
    drain_frame(5, 4'b1111);
  endtask

  task automatic test_stall;
    for (int i = 0; i < 5; i++) frame[i] = 8'(i + 1);
    load_frame(5, 5, 1'b0);
    drain_frame(5, 4'b1001);
  endtask

  task automatic test_single;
    frame[0] = 8'hA5;
    load_frame(1, 1, 1'b0);
    drain_frame(1, 4'b1111);
  endtask

  task automatic test_back_to_back;
    frame[0] = 8'h10; frame[1] = 8'h11; frame[2] = 8'h12;
    load_frame(3, 3, 1'b0);
    drain_frame(3, 4'b1111);
    frame[0] = 8'h20; frame[1] = 8'h21;
    load_frame(2, 2, 1'b0);
    drain_frame(2, 4'b1111);
  endtask

  task automatic test_overflow;
    use_small = 1'b1;
    #1;
    for (int i = 0; i < 7; i++) frame[i] = 8'(i + 1);
    load_frame(7, 4, 1'b1);
    drain_frame(4, 4'b1111);
    use_small = 1'b0;
    #1;
  endtask

  task automatic test_reset_mid_send;
    for (int i = 0; i < 5; i++) frame[i] = 8'(i + 1);
    load_frame(5, 5, 1'b0);
    ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    total++;
    if (m_valid !== 1'b1 || m_data !== 8'h01) begin
      bad++;
      $display("FAIL midsend_valid: valid=%b data=%h want 1,01", m_valid, m_data);
    end
    #2 rst_n = 1'b0;
    #1;
    check_reset_values("midsend_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    total++;
    if (m_tready !== 1'b0 || m_busy !== 1'b0) begin
      bad++;
      $display("FAIL midsend_idle: tready=%b busy=%b want 0,0", m_tready, m_busy);
    end
    @(posedge clk); #1;
    total++;
    if (m_tready !== 1'b1 || m_valid !== 1'b0 || m_empty !== 1'b1 || m_len !== '0) begin
      bad++;
      $display("FAIL midsend_release: tready=%b valid=%b empty=%b len=%0d want 1,0,1,0",
               m_tready, m_valid, m_empty, m_len);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_stall;
    test_single;
    test_back_to_back;
    test_overflow;
    test_reset_mid_send;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
